gmii_rx: RTL
============

# gmii_rx

Receive-side GMII frame parser for the Ethernet video/audio transport. Sits between the PHY's GMII receive pins and the video/audio sink FIFOs on the display-side board. Accepts the UDP frames the transmit path produces: video lines, audio (AUX) blocks, and video-plus-AUX frames. Strips the Ethernet, IP and UDP headers, and streams payload words out. Checks the CRC-32 and reports each frame as committed or dropped.

## Interface
Parameters:
- `own_mac` — default `48'h00_23_45_67_89_02` — station MAC; the last byte is decremented by `id`.
- `udp_port` — default `16'h3039` — accepted UDP destination port.
- `vid_bytes` — default `11'd1280` — video payload bytes per frame.
- `aux_bytes` — default `6'd48` — AUX payload bytes per block.

Ports:
- `rx_clk` — in — 1 — GMII receive clock, 125 MHz; the only clock.
- `sys_rst` — in — 1 — reset, asynchronous, active-high.
- `id` — in — 1 — board id; expected destination MAC low byte is `own_mac[7:0] - id`.
- `rx_dv` — in — 1 — GMII data valid.
- `rx_er` — in — 1 — GMII receive error.
- `rxd` — in — 8 — GMII receive data.
- `vid_hdr_valid` — out — 1 — one-cycle pulse; `vid_hdr` is valid.
- `vid_hdr` — out — 16 — the two resolution bytes, first received in `[15:8]`.
- `vid_wr_en` — out — 1 — video word strobe.
- `vid_din` — out — 16 — {even byte, odd byte}, i.e. {Y, C}.
- `aux_hdr_valid` — out — 1 — one-cycle pulse per AUX block.
- `aux_hdr` — out — 16 — AUXID bytes; `[15:12]` holds the remaining-block nibble.
- `aux_wr_en` — out — 1 — AUX word strobe.
- `aux_din` — out — 24 — three consecutive AUX bytes, first byte in `[23:16]`.
- `frm_commit` — out — 1 — one-cycle pulse; frame ended with a good CRC.
- `frm_drop` — out — 1 — one-cycle pulse; an accepted frame failed.
- `frm_type` — out — 2 — packet identifier of the last accepted frame: 0 = video, 1 = audio, 2 = vidax.

Reset value of every output is 0.

## Operation
States: IDLE, PRE, ETH, IP, PID, RESOL, VID, AUXID, AUX, FCS, SKIP.

- **IDLE:** `rx_dv`=1 and `rxd`=0x55 → PRE.
- **PRE:** waits for 0xD5 (SFD) → ETH, clears the CRC. Any byte other than 0x55/0xD5 → SKIP.
- **ETH:** 14 bytes. The destination MAC must match `own_mac` with the `id` adjustment, and the EtherType must be 0x0800. Otherwise → SKIP.
- **IP:** 28 bytes, covering the IPv4 header plus the UDP header. The protocol byte (offset 9) must be 0x11 and the UDP destination port (offsets 22–23) must be `udp_port`. Otherwise → SKIP. IP and UDP checksums are not checked.
- **PID:** one byte; latched into `frm_type`.
  - 0 or 2 → RESOL.
  - 1 → AUXID.
  - Any other value → SKIP.
- **RESOL:** 2 bytes → `vid_hdr_valid` pulse, then → VID.
- **VID:** `vid_bytes` bytes, paired into `vid_bytes/2` words.
  - At the last byte, type 0 → FCS and type 2 → AUXID.
- **AUXID:** 2 bytes → `aux_hdr_valid` pulse, then → AUX.
- **AUX:** `aux_bytes` bytes packed into `aux_bytes/3` words (16 at the default).
  - At the last byte: if the block's nibble ≤ 1 → FCS, else → AUXID.
- **FCS:** 4 bytes are fed into the CRC. The residue is checked once `rx_dv` falls.
  - Residue equal to `32'hC704DD7B` → `frm_commit`.
  - Otherwise → `frm_drop`.
  - Then → IDLE.
- **SKIP:** waits for `rx_dv`=0, then → IDLE. No pulse unless PID was already passed.

Abort rules:
- `rx_dv` falling early, or `rx_er`=1 in any state after PID → `frm_drop` (once), then → SKIP/IDLE.
- Before PID, the same events → SKIP silently.
- Extra bytes after FCS while `rx_dv`=1 → `frm_drop`.

## Timing
- Inputs are registered once, so all outputs lag the wire by 2 cycles from the sampled last byte of each unit.
- `vid_wr_en` pulses on the cycle after each odd byte. `aux_wr_en` pulses after every third AUX byte.
- `frm_commit`/`frm_drop` fire 2 cycles after the first sample with `rx_dv`=0.
- `frm_commit` and `frm_drop` are never asserted in the same cycle.
- A new preamble is accepted on the cycle after returning to IDLE; no inter-frame gap is enforced.
- Asynchronous reset mid-frame clears state and outputs immediately; no drop pulse is generated.

## Configuration
- **`GMII_RX_STATS_EN`** defined: adds three 16-bit saturating outputs, cleared by reset:
  - `stat_good` increments on `frm_commit`.
  - `stat_bad` increments on `frm_drop`.
  - `stat_skip` increments on entry to SKIP from ETH/IP/PID.
- Undefined: the ports and counters are absent.

## Structure
- Shared package `gmii_pkg`: state encoding, packet-ID constants (`video`=0, `audio`=1, `vidax`=2), the preamble/SFD constants and the CRC residue constant.
- One sub-module, `crc32_chk`: byte-wide CRC-32 (polynomial 0x04C11DB7, reflected, init all-ones), with `init`/`en`/`data` inputs and `residue_ok` output.

## Test plan
- **Good video frame, id=0:** 640 `vid_wr_en` pulses with `vid_din` matching byte pairs, one `vid_hdr_valid`, then `frm_commit`, `frm_type`=0.
- **Same frame with one payload bit flipped:** all 640 words are still emitted, then `frm_drop`, with no `frm_commit`.
- **Audio frame with AUXID nibbles 3,2,1:** 3 `aux_hdr_valid` pulses and 48 `aux_wr_en` pulses, then `frm_commit`, `frm_type`=1.
- **Vidax frame (nibble 1):** 640 video words and 16 AUX words, then `frm_commit`, `frm_type`=2.
- **Wrong destination MAC (`..:02`, id=1), then wrong UDP port 0x3038:** no strobes and no pulses; with `GMII_RX_STATS_EN`, `stat_skip`=2.
- **`rx_dv` dropped at video byte 100:** 50 words emitted, one `frm_drop`, and a back-to-back next good frame is committed.

Source files
------------

// File: rtl/gmii_pkg.sv
// gmii_pkg: constants and types shared by the GMII receive parser.
// Holds the parser state encoding, the packet-ID values, the preamble/SFD bytes,
// the CRC-32 residue and a byte-wide reflected CRC-32 update function.
package gmii_pkg;

    typedef enum logic [3:0] {
        StIdle, StPre, StEth, StIp, StPid, StResol, StVid, StAuxid, StAux, StFcs, StSkip
    } gmii_state_e;

    localparam logic [1:0]  PidVideo   = 2'd0;
    localparam logic [1:0]  PidAudio   = 2'd1;
    localparam logic [1:0]  PidVidax   = 2'd2;

    localparam logic [7:0]  Preamble   = 8'h55;
    localparam logic [7:0]  Sfd        = 8'hD5;

    // Residue of the bit-reversed (MSB-first) view of the CRC register.
    localparam logic [31:0] CrcResidue = 32'hC704DD7B;

    // One byte of reflected CRC-32 (poly 0x04C11DB7), data LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_chk.sv
// crc32_chk: byte-wide Ethernet CRC-32 checker.
// Ports: clk/rst (async, active-high), init loads all-ones, en folds data into
// the register, residue_ok flags that the bytes so far (FCS included) are good.
module crc32_chk
    import gmii_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       init,
    input  logic       en,
    input  logic [7:0] data,
    output logic       residue_ok
);

    logic [31:0] crc_q, crc_d, crc_rev;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = '1;
        end else if (en) begin
            crc_d = crc32_byte(crc_q, data);
        end
    end

    always_comb begin
        crc_rev = '0;
        for (int i = 0; i < 32; i++) begin
            crc_rev[i] = crc_q[31-i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= '1;
        else     crc_q <= crc_d;
    end

    assign residue_ok = (crc_rev == CrcResidue);

endmodule

// File: rtl/gmii_rx.sv
// gmii_rx: GMII receive frame parser for the video/audio transport.
// Strips Ethernet/IP/UDP headers, emits video words ({Y,C}), AUX words (3 bytes),
// the resolution and AUXID headers, and a commit/drop pulse per accepted frame.
// Ports: rx_clk, sys_rst (async, active-high), id, rx_dv/rx_er/rxd (GMII in);
// vid_*, aux_* (payload out), frm_commit/frm_drop/frm_type (frame status).
// Optional: define GMII_RX_STATS_EN to add stat_good/stat_bad/stat_skip counters.
module gmii_rx
    import gmii_pkg::*;
#(
    parameter logic [47:0] own_mac   = 48'h00_23_45_67_89_02,
    parameter logic [15:0] udp_port  = 16'h3039,
    parameter logic [10:0] vid_bytes = 11'd1280,
    parameter logic [5:0]  aux_bytes = 6'd48
) (
    input  logic        rx_clk,
    input  logic        sys_rst,
    input  logic        id,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [7:0]  rxd,
    output logic        vid_hdr_valid,
    output logic [15:0] vid_hdr,
    output logic        vid_wr_en,
    output logic [15:0] vid_din,
    output logic        aux_hdr_valid,
    output logic [15:0] aux_hdr,
    output logic        aux_wr_en,
    output logic [23:0] aux_din,
    output logic        frm_commit,
    output logic        frm_drop,
    output logic [1:0]  frm_type
`ifdef GMII_RX_STATS_EN
    ,
    output logic [15:0] stat_good,
    output logic [15:0] stat_bad,
    output logic [15:0] stat_skip
`endif
);

    localparam logic [10:0] VidLast = vid_bytes - 11'd1;
    localparam logic [10:0] AuxLast = {5'd0, aux_bytes} - 11'd1;

    gmii_state_e state_q, state_d;
    logic        dv_q, er_q;
    logic [7:0]  d_q;
    logic [10:0] cnt_q, cnt_d;
    logic [1:0]  sub_q, sub_d;
    logic [7:0]  b0_q, b0_d, b1_q, b1_d;
    logic [3:0]  nib_q, nib_d;
    logic        vhv_q, vhv_d, vwe_q, vwe_d, ahv_q, ahv_d, awe_q, awe_d;
    logic [15:0] vhdr_q, vhdr_d, vdin_q, vdin_d, ahdr_q, ahdr_d;
    logic [23:0] adin_q, adin_d;
    logic        commit_q, commit_d, drop_q, drop_d;
    logic [1:0]  type_q, type_d;
    logic        crc_init, crc_en, residue_ok, skip_evt;
    logic        eth_ok, ip_ok, post_pid;
    logic [47:0] mac_exp;

    crc32_chk u_crc (
        .clk        (rx_clk),
        .rst        (sys_rst),
        .init       (crc_init),
        .en         (crc_en),
        .data       (d_q),
        .residue_ok (residue_ok)
    );

    // Per-byte header field checks, indexed by position within the header.
    always_comb begin
        mac_exp = {own_mac[47:8], own_mac[7:0] - {7'd0, id}};
        eth_ok  = 1'b1;
        ip_ok   = 1'b1;
        case (cnt_q)
            11'd0:   eth_ok = (d_q == mac_exp[47:40]);
            11'd1:   eth_ok = (d_q == mac_exp[39:32]);
            11'd2:   eth_ok = (d_q == mac_exp[31:24]);
            11'd3:   eth_ok = (d_q == mac_exp[23:16]);
            11'd4:   eth_ok = (d_q == mac_exp[15:8]);
            11'd5:   eth_ok = (d_q == mac_exp[7:0]);
            11'd12:  eth_ok = (d_q == 8'h08);
            11'd13:  eth_ok = (d_q == 8'h00);
            default: eth_ok = 1'b1;
        endcase
        case (cnt_q)
            11'd9:   ip_ok = (d_q == 8'h11);
            11'd22:  ip_ok = (d_q == udp_port[15:8]);
            11'd23:  ip_ok = (d_q == udp_port[7:0]);
            default: ip_ok = 1'b1;
        endcase
    end

    assign post_pid = (state_q == StResol) || (state_q == StVid) || (state_q == StAuxid) ||
                      (state_q == StAux) || (state_q == StFcs);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sub_d    = sub_q;
        b0_d     = b0_q;
        b1_d     = b1_q;
        nib_d    = nib_q;
        vhdr_d   = vhdr_q;
        vdin_d   = vdin_q;
        ahdr_d   = ahdr_q;
        adin_d   = adin_q;
        type_d   = type_q;
        vhv_d    = 1'b0;
        vwe_d    = 1'b0;
        ahv_d    = 1'b0;
        awe_d    = 1'b0;
        commit_d = 1'b0;
        drop_d   = 1'b0;
        crc_init = 1'b0;
        crc_en   = 1'b0;
        skip_evt = 1'b0;

        // After PID, an error or early loss of rx_dv drops the frame. FCS handles
        // the rx_dv fall itself, since that is its normal end.
        if (post_pid && (er_q || (!dv_q && state_q != StFcs))) begin
            drop_d  = 1'b1;
            state_d = dv_q ? StSkip : StIdle;
        end else begin
            unique case (state_q)
                StIdle: if (dv_q && d_q == Preamble) state_d = StPre;
                StPre: begin
                    if (!dv_q) state_d = StIdle;
                    else if (er_q) state_d = StSkip;
                    else if (d_q == Sfd) begin
                        state_d  = StEth;
                        cnt_d    = '0;
                        crc_init = 1'b1;
                    end else if (d_q != Preamble) state_d = StSkip;
                end
                StEth, StIp: begin
                    if (!dv_q) state_d = StIdle;
                    else begin
                        crc_en = 1'b1;
                        cnt_d  = cnt_q + 11'd1;
                        if (er_q || !(state_q == StEth ? eth_ok : ip_ok)) begin
                            state_d  = StSkip;
                            skip_evt = 1'b1;
                        end else if (state_q == StEth && cnt_q == 11'd13) begin
                            state_d = StIp;
                            cnt_d   = '0;
                        end else if (state_q == StIp && cnt_q == 11'd27) begin
                            state_d = StPid;
                        end
                    end
                end
                StPid: begin
                    if (!dv_q) state_d = StIdle;
                    else begin
                        crc_en = 1'b1;
                        cnt_d  = '0;
                        if (er_q || d_q > {6'd0, PidVidax}) begin
                            state_d  = StSkip;
                            skip_evt = 1'b1;
                        end else begin
                            type_d  = d_q[1:0];
                            state_d = (d_q[1:0] == PidAudio) ? StAuxid : StResol;
                        end
                    end
                end
                StResol, StAuxid: begin
                    crc_en = 1'b1;
                    cnt_d  = cnt_q + 11'd1;
                    if (cnt_q == 11'd0) b0_d = d_q;
                    else begin
                        cnt_d = '0;
                        sub_d = '0;
                        if (state_q == StResol) begin
                            vhdr_d  = {b0_q, d_q};
                            vhv_d   = 1'b1;
                            state_d = StVid;
                        end else begin
                            ahdr_d  = {b0_q, d_q};
                            ahv_d   = 1'b1;
                            nib_d   = b0_q[7:4];
                            state_d = StAux;
                        end
                    end
                end
                StVid: begin
                    crc_en = 1'b1;
                    cnt_d  = cnt_q + 11'd1;
                    if (!cnt_q[0]) b0_d = d_q;
                    else begin
                        vdin_d = {b0_q, d_q};
                        vwe_d  = 1'b1;
                    end
                    if (cnt_q == VidLast) begin
                        cnt_d   = '0;
                        state_d = (type_q == PidVidax) ? StAuxid : StFcs;
                    end
                end
                StAux: begin
                    crc_en = 1'b1;
                    cnt_d  = cnt_q + 11'd1;
                    sub_d  = (sub_q == 2'd2) ? 2'd0 : sub_q + 2'd1;
                    case (sub_q)
                        2'd0:    b0_d = d_q;
                        2'd1:    b1_d = d_q;
                        default: begin
                            adin_d = {b0_q, b1_q, d_q};
                            awe_d  = 1'b1;
                        end
                    endcase
                    if (cnt_q == AuxLast) begin
                        cnt_d   = '0;
                        sub_d   = '0;
                        state_d = (nib_q <= 4'd1) ? StFcs : StAuxid;
                    end
                end
                StFcs: begin
                    if (!dv_q) begin
                        commit_d = (cnt_q == 11'd4) && residue_ok;
                        drop_d   = !commit_d;
                        state_d  = StIdle;
                    end else if (cnt_q == 11'd4) begin
                        // Trailing bytes beyond the FCS.
                        drop_d  = 1'b1;
                        state_d = StSkip;
                    end else begin
                        crc_en = 1'b1;
                        cnt_d  = cnt_q + 11'd1;
                    end
                end
                StSkip: if (!dv_q) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge rx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            dv_q     <= 1'b0;
            er_q     <= 1'b0;
            d_q      <= '0;
            state_q  <= StIdle;
            cnt_q    <= '0;
            sub_q    <= '0;
            b0_q     <= '0;
            b1_q     <= '0;
            nib_q    <= '0;
            vhv_q    <= 1'b0;
            vwe_q    <= 1'b0;
            ahv_q    <= 1'b0;
            awe_q    <= 1'b0;
            vhdr_q   <= '0;
            vdin_q   <= '0;
            ahdr_q   <= '0;
            adin_q   <= '0;
            commit_q <= 1'b0;
            drop_q   <= 1'b0;
            type_q   <= '0;
        end else begin
            dv_q     <= rx_dv;
            er_q     <= rx_er;
            d_q      <= rxd;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sub_q    <= sub_d;
            b0_q     <= b0_d;
            b1_q     <= b1_d;
            nib_q    <= nib_d;
            vhv_q    <= vhv_d;
            vwe_q    <= vwe_d;
            ahv_q    <= ahv_d;
            awe_q    <= awe_d;
            vhdr_q   <= vhdr_d;
            vdin_q   <= vdin_d;
            ahdr_q   <= ahdr_d;
            adin_q   <= adin_d;
            commit_q <= commit_d;
            drop_q   <= drop_d;
            type_q   <= type_d;
        end
    end

    assign vid_hdr_valid = vhv_q;
    assign vid_hdr       = vhdr_q;
    assign vid_wr_en     = vwe_q;
    assign vid_din       = vdin_q;
    assign aux_hdr_valid = ahv_q;
    assign aux_hdr       = ahdr_q;
    assign aux_wr_en     = awe_q;
    assign aux_din       = adin_q;
    assign frm_commit    = commit_q;
    assign frm_drop      = drop_q;
    assign frm_type      = type_q;

`ifdef GMII_RX_STATS_EN
    logic [15:0] good_q, bad_q, skip_q;

    always_ff @(posedge rx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            good_q <= '0;
            bad_q  <= '0;
            skip_q <= '0;
        end else begin
            if (commit_d && good_q != 16'hFFFF) good_q <= good_q + 16'd1;
            if (drop_d && bad_q != 16'hFFFF)    bad_q  <= bad_q + 16'd1;
            if (skip_evt && skip_q != 16'hFFFF) skip_q <= skip_q + 16'd1;
        end
    end

    assign stat_good = good_q;
    assign stat_bad  = bad_q;
    assign stat_skip = skip_q;
`else
    logic stats_unused;
    assign stats_unused = skip_evt;
`endif

endmodule
